// File: rtl/symbol_framer.sv
// symbol_framer
//   Feeds the 13x zero-stuffing upsampler. Bytes arrive over a valid/ready
//   handshake and each one is split into two 4-bit symbols. The symbols can
//   optionally be Gray coded. Each symbol is presented on symbol_out with a
//   one-cycle new_symbol strobe. Strobes are spaced SYMBOL_PERIOD clocks
//   apart, and symbol_out is held stable between strobes.
//
// Parameters
//   SYMBOL_PERIOD : clocks between consecutive strobes (>= 14)
//   MSB_FIRST     : 1 sends in_data[7:4] first, 0 sends in_data[3:0] first
//   GRAY_MAP      : 1 maps each nibble n to n ^ (n >> 1)
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : synchronous active-low reset
//   enable         : low stops new strobes and underrun counting
//   in_valid       : upstream byte valid
//   in_data[7:0]   : upstream byte
//   in_ready       : a byte can be accepted this cycle (combinational)
//   new_symbol     : registered one-cycle strobe for a new symbol
//   symbol_out[3:0]: registered symbol, held until the next strobe
//   underrun_count : saturating count of slots that found no data
module symbol_framer #(
  parameter int SYMBOL_PERIOD = 14,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit GRAY_MAP      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       new_symbol,
  output logic [3:0] symbol_out,
  output logic [7:0] underrun_count
);

  localparam int CW = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SYMBOL_PERIOD - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    byte_reg, byte_next;
  logic          first_pend_reg, first_pend_next;
  logic          second_pend_reg, second_pend_next;
  logic          busy_reg, busy_next;
  logic          new_symbol_reg, new_symbol_next;
  logic [3:0]    symbol_reg, symbol_next;
  logic [7:0]    underrun_reg, underrun_next;

  logic [3:0] first_nib;
  logic [3:0] second_nib;
  logic [3:0] raw_nib;
  logic [3:0] gray_nib;
  logic [3:0] mapped_nib;
  logic       slot;
  logic       any_pend;
  logic       issue;
  logic       issue_second;
  logic       underrun;
  logic       handshake;

  assign first_nib  = MSB_FIRST ? byte_reg[7:4] : byte_reg[3:0];
  assign second_nib = MSB_FIRST ? byte_reg[3:0] : byte_reg[7:4];

  // The first flag is only ever set together with the second one, so the
  // first flag alone decides which nibble goes out next.
  assign raw_nib = first_pend_reg ? first_nib : second_nib;

  // Gray code: each bit is XORed with its upper neighbour; the MSB passes.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_gray
      assign gray_nib[gi] = raw_nib[gi] ^ raw_nib[gi+1];
    end
  endgenerate
  assign gray_nib[3] = raw_nib[3];

  assign mapped_nib = GRAY_MAP ? gray_nib : raw_nib;

  assign slot         = (cnt_reg == '0);
  assign any_pend     = first_pend_reg | second_pend_reg;
  assign issue        = slot & enable & any_pend;
  assign issue_second = issue & ~first_pend_reg;
  assign underrun     = slot & enable & busy_reg & ~any_pend;

  // A new byte may land on the same edge that issues the last nibble of the
  // current byte, so streaming never leaves an empty slot.
  assign in_ready  = ~any_pend | issue_second;
  assign handshake = in_valid & in_ready;

  always_comb begin
    cnt_next         = (cnt_reg != '0) ? cnt_reg - CW'(1) : cnt_reg;
    byte_next        = byte_reg;
    first_pend_next  = first_pend_reg;
    second_pend_next = second_pend_reg;
    busy_next        = busy_reg;
    new_symbol_next  = 1'b0;
    symbol_next      = symbol_reg;
    underrun_next    = underrun_reg;

    if (issue) begin
      new_symbol_next = 1'b1;
      symbol_next     = mapped_nib;
      cnt_next        = CNT_RELOAD;
      busy_next       = 1'b1;
      if (first_pend_reg) begin
        first_pend_next = 1'b0;
      end else begin
        second_pend_next = 1'b0;
      end
    end else if (underrun) begin
      // busy drops so a line that stays idle is counted only once.
      busy_next = 1'b0;
      if (underrun_reg != 8'hFF) begin
        underrun_next = underrun_reg + 8'd1;
      end
    end

    // Loading overrides the flag clear of a simultaneous last-nibble issue.
    if (handshake) begin
      byte_next        = in_data;
      first_pend_next  = 1'b1;
      second_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      byte_reg        <= 8'h00;
      first_pend_reg  <= 1'b0;
      second_pend_reg <= 1'b0;
      busy_reg        <= 1'b0;
      new_symbol_reg  <= 1'b0;
      symbol_reg      <= 4'h0;
      underrun_reg    <= 8'h00;
    end else begin
      cnt_reg         <= cnt_next;
      byte_reg        <= byte_next;
      first_pend_reg  <= first_pend_next;
      second_pend_reg <= second_pend_next;
      busy_reg        <= busy_next;
      new_symbol_reg  <= new_symbol_next;
      symbol_reg      <= symbol_next;
      underrun_reg    <= underrun_next;
    end
  end

  assign new_symbol     = new_symbol_reg;
  assign symbol_out     = symbol_reg;
  assign underrun_count = underrun_reg;

endmodule

// File: tb/tb_symbol_framer.sv
// Testbench for symbol_framer. Three instances share one stimulus stream:
//   u0: MSB_FIRST=1, GRAY_MAP=0
//   u1: MSB_FIRST=1, GRAY_MAP=1
//   u2: MSB_FIRST=0, GRAY_MAP=1
// Expected symbols are queued when a byte is sent. Monitors pop the queues
// on every strobe and compare the values.
module tb_symbol_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic [7:0] in_data;

  logic       ir0, ir1, ir2;
  logic       ns0, ns1, ns2;
  logic [3:0] so0, so1, so2;
  logic [7:0] uc0, uc1, uc2;

  always #5 clk = ~clk;

  symbol_framer #(.SYMBOL_PERIOD(14), .MSB_FIRST(1'b1), .GRAY_MAP(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ir0), .new_symbol(ns0), .symbol_out(so0),
    .underrun_count(uc0));

  symbol_framer #(.SYMBOL_PERIOD(14), .MSB_FIRST(1'b1), .GRAY_MAP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ir1), .new_symbol(ns1), .symbol_out(so1),
    .underrun_count(uc1));

  symbol_framer #(.SYMBOL_PERIOD(14), .MSB_FIRST(1'b0), .GRAY_MAP(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ir2), .new_symbol(ns2), .symbol_out(so2),
    .underrun_count(uc2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  int         st[$];   // strobe cycles seen on u0

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_check(input int id, input logic [3:0] act);
    logic [3:0] e;
    int have;
    e = 4'h0;
    case (id)
      0:       have = q0.size();
      1:       have = q1.size();
      default: have = q2.size();
    endcase
    tests++;
    if (have == 0) begin
      fails++;
      $display("FAIL strobe_dut%0d: unexpected strobe with symbol 0x%h at cycle %0d, required none",
               id, act, cyc);
    end else begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      $display("[TB] dut%0d strobe cycle %0d symbol 0x%h expected 0x%h", id, cyc, act, e);
      if (act != e) begin
        fails++;
        $display("FAIL symbol_dut%0d: got 0x%h, required 0x%h (cycle %0d)", id, act, e, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ns0) begin
      st.push_back(cyc);
      mon_check(0, so0);
    end
  end
  always @(negedge clk) if (ns1) mon_check(1, so1);
  always @(negedge clk) if (ns2) mon_check(2, so2);

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    q0.push_back(a);
    q1.push_back(b);
    q2.push_back(c);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic abort(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at cycle %0d, required the event", name, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench stopped on expired wait");
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_st(input int k);
    int n;
    n = 0;
    while (st.size() < k && n < 400) begin
      tick();
      n++;
    end
    if (st.size() < k) abort("strobe_timeout");
  endtask

  // hs is the cycle in which in_valid && in_ready was presented.
  task automatic send_byte(input logic [7:0] b, output int hs);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!ir0 && n < 400) begin
      tick();
      n++;
    end
    if (!ir0) abort("ready_timeout");
    hs = cyc;
    $display("[TB] send byte 0x%h handshake cycle %0d", b, hs);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    st.delete();
  endtask

  int h, h2, h3, s0;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    check("rst_new_symbol", ns0, 0);
    check("rst_symbol_out", so0, 0);
    check("rst_underrun", uc0, 0);
    check("rst_in_ready", ir0, 1);
    check("rst_in_ready_u2", ir2, 1);
    rst_n = 1'b1;
    tick();

    // Single byte 0xA5
    do_reset();
    push(4'hA, 4'hF, 4'h7);
    push(4'h5, 4'h7, 4'hF);
    send_byte(8'hA5, h);
    wait_st(1);
    s0 = st[0];
    check("a5_latency", s0, h + 2);
    wait_cyc(s0 + 1);
    check("a5_ready_pending", ir0, 0);
    wait_cyc(s0 + 7);
    check("a5_symbol_hold", so0, 4'hA);
    wait_cyc(s0 + 13);
    check("a5_ready_issue", ir0, 1);
    wait_st(2);
    check("a5_spacing", st[1] - st[0], 14);

    // Back-to-back 0x12, 0x34, 0x56
    do_reset();
    push(4'h1, 4'h1, 4'h3);
    push(4'h2, 4'h3, 4'h1);
    send_byte(8'h12, h);
    push(4'h3, 4'h2, 4'h6);
    push(4'h4, 4'h6, 4'h2);
    send_byte(8'h34, h2);
    push(4'h5, 4'h7, 4'h5);
    push(4'h6, 4'h5, 4'h7);
    send_byte(8'h56, h3);
    wait_st(6);
    for (int i = 1; i < 6; i++) check("b2b_spacing", st[i] - st[i-1], 14);
    check("b2b_hs2_on_issue", h2, st[1] - 1);
    check("b2b_hs3_on_issue", h3, st[3] - 1);
    wait_cyc(st[5] + 1);
    check("b2b_underrun", uc0, 0);

    // Gray mapping of 0x37
    do_reset();
    push(4'h3, 4'h2, 4'h4);
    push(4'h7, 4'h4, 4'h2);
    send_byte(8'h37, h);
    wait_st(2);
    check("gray_spacing", st[1] - st[0], 14);

    // Underrun after 0xFF, then idle, then restart
    do_reset();
    push(4'hF, 4'h8, 4'h8);
    push(4'hF, 4'h8, 4'h8);
    send_byte(8'hFF, h);
    wait_st(2);
    s0 = st[1];
    wait_cyc(s0 + 12);
    check("ur_before_slot", uc0, 0);
    wait_cyc(s0 + 14);
    check("ur_first_slot", uc0, 1);
    check("ur_first_slot_u2", uc2, 1);
    wait_cyc(s0 + 114);
    check("ur_idle_hold", uc0, 1);
    check("ur_idle_no_strobe", st.size(), 2);
    push(4'h8, 4'hC, 4'h1);
    push(4'h1, 4'h1, 4'hC);
    send_byte(8'h81, h);
    wait_st(3);
    check("ur_restart_latency", st[2], h + 2);
    wait_st(4);
    wait_cyc(st[3] + 12);
    check("ur_restart_no_count", uc0, 1);

    // enable low for 30 cycles between the nibbles of 0x9E
    do_reset();
    push(4'h9, 4'hD, 4'h9);
    push(4'hE, 4'h9, 4'hD);
    send_byte(8'h9E, h);
    wait_st(1);
    s0 = st[0];
    wait_cyc(s0 + 3);
    enable = 1'b0;
    wait_cyc(s0 + 33);
    check("en_gap_no_strobe", st.size(), 1);
    check("en_gap_no_underrun", uc0, 0);
    enable = 1'b1;
    wait_st(2);
    check("en_resume_cycle", st[1], s0 + 34);

    // Reset between the two strobes of 0xC3
    do_reset();
    push(4'hC, 4'hA, 4'h2);
    send_byte(8'hC3, h);
    wait_st(1);
    s0 = st[0];
    wait_cyc(s0 + 5);
    rst_n = 1'b0;
    tick();
    check("mid_rst_new_symbol", ns0, 0);
    check("mid_rst_symbol_out", so0, 0);
    check("mid_rst_in_ready", ir0, 1);
    rst_n = 1'b1;
    wait_cyc(s0 + 50);
    check("mid_rst_no_second", st.size(), 1);

    // 300 underruns saturate at 255
    do_reset();
    for (int i = 0; i < 300; i++) begin
      push(4'h0, 4'h0, 4'h0);
      push(4'h0, 4'h0, 4'h0);
      send_byte(8'h00, h);
      wait_cyc(h + 31);
      if (i == 9) check("sat_count_10", uc0, 10);
    end
    check("sat_count_u0", uc0, 255);
    check("sat_count_u1", uc1, 255);

    tick();
    check("queue_empty_u0", q0.size(), 0);
    check("queue_empty_u1", q1.size(), 0);
    check("queue_empty_u2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
